fractal_sync_mp_cam_sched: RTL and testbench

// - Front-end scheduler for fractal_sync_mp_cam. Shares N_PORTS CAM ports among N_REQ sync requesters.
// - Arbitrates requests round-robin and drives CAM lookups/writes.
// - Parks requesters whose signature missed; releases them when a partner hits the same signature.
// - Tracks CAM line occupancy so a write is never issued to a full CAM.

---
 rtl/fractal_sync_mp_cam_sched.sv | 173 +++++++++++++++++
 tb/tb_fractal_sync_mp_cam_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_mp_cam_sched.sv
`timescale 1ns/1ps
// fractal_sync_mp_cam_sched: round-robin front end sharing N_PORTS CAM ports among N_REQ sync requesters.
// Define FRACTAL_SYNC_SCHED_STATS_EN to add the match_cnt_o completed-match counter.
module fractal_sync_mp_cam_sched #(
  parameter int unsigned SIG_WIDTH = 1,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned N_LINES   = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  // Requests: req_valid_i/req_sig_i are held until req_ready_o pulses for one cycle (the grant consumes them).
  // Responses: rsp_valid_o is held until a cycle in which rsp_ready_i is also high.
  input  logic [N_REQ-1:0]                    req_valid_i,
  input  logic [N_REQ-1:0][SIG_WIDTH-1:0]     req_sig_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  output logic [N_REQ-1:0]                    rsp_valid_o,
  input  logic [N_REQ-1:0]                    rsp_ready_i,
  output logic [N_PORTS-1:0][SIG_WIDTH-1:0]   cam_sig_o,
  output logic [N_PORTS-1:0]                  cam_write_o,
  input  logic [N_PORTS-1:0]                  cam_present_i,
  output logic [$clog2(N_LINES+1)-1:0]        occupancy_o
`ifdef FRACTAL_SYNC_SCHED_STATS_EN
  ,
  output logic [31:0]                         match_cnt_o
`endif
);
  localparam int unsigned OCC_W = $clog2(N_LINES + 1);
  localparam int unsigned PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} req_state_e;

  req_state_e                         state_q [N_REQ];
  req_state_e                         state_d [N_REQ];
  logic [SIG_WIDTH-1:0]               wait_sig_q [N_REQ];
  logic [SIG_WIDTH-1:0]               wait_sig_d [N_REQ];
  logic [OCC_W-1:0]                   occ_q, occ_d;
  logic [PTR_W-1:0]                   rr_q, rr_d;

  logic [N_REQ-1:0]                   grant;
  logic [N_REQ-1:0]                   hit_vec;
  logic [N_PORTS-1:0][SIG_WIDTH-1:0]  port_sig;
  logic [N_PORTS-1:0]                 port_wr;
  logic [N_PORTS-1:0]                 port_hit;
  logic [PTR_W-1:0]                   cand;
  logic [SIG_WIDTH-1:0]               cmp_sig;
  logic                               pred_hit, dup;
  int                                 free_lines, n_grant, n_pred_miss, scan_idx, nxt_idx;
  int                                 n_hit, n_miss;

  // CAM contents always equal the signatures of WAIT requesters, so a hit is predicted from
  // the waiter table; only predicted misses consume a free line, which lets partners of a
  // full CAM still be granted.
  always_comb begin
    grant       = '0;
    port_sig    = '0;
    port_wr     = '0;
    rr_d        = rr_q;
    n_grant     = 0;
    n_pred_miss = 0;
    free_lines  = int'(N_LINES) - int'(occ_q);
    cand        = '0;
    pred_hit    = 1'b0;
    dup         = 1'b0;
    scan_idx    = 0;
    nxt_idx     = 0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      scan_idx = int'(rr_q) + j;
      if (scan_idx >= int'(N_REQ)) scan_idx = scan_idx - int'(N_REQ);
      cand     = PTR_W'(scan_idx);
      pred_hit = 1'b0;
      dup      = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (state_q[i] == WAIT && wait_sig_q[i] == req_sig_i[cand]) pred_hit = 1'b1;
      end
      for (int k = 0; k < int'(N_PORTS); k++) begin
        if (port_wr[k] && port_sig[k] == req_sig_i[cand]) dup = 1'b1;
      end
      if (rst_ni && req_valid_i[cand] && state_q[cand] == IDLE && !dup &&
          n_grant < int'(N_PORTS) && (pred_hit || n_pred_miss < free_lines)) begin
        for (int k = 0; k < int'(N_PORTS); k++) begin
          if (k == n_grant) begin
            port_sig[k] = req_sig_i[cand];
            port_wr[k]  = 1'b1;
          end
        end
        grant[cand] = 1'b1;
        n_grant     = n_grant + 1;
        if (!pred_hit) n_pred_miss = n_pred_miss + 1;
        nxt_idx = int'(cand) + 1;
        if (nxt_idx >= int'(N_REQ)) nxt_idx = 0;
        rr_d = PTR_W'(nxt_idx);
      end
    end
  end

  assign port_hit = port_wr & cam_present_i;

  always_comb begin
    n_hit   = 0;
    n_miss  = 0;
    cmp_sig = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      state_d[i]    = state_q[i];
      wait_sig_d[i] = wait_sig_q[i];
      // A waiter is released by a port hit on its stored signature; a grantee hits on its own.
      cmp_sig    = (state_q[i] == WAIT) ? wait_sig_q[i] : req_sig_i[i];
      hit_vec[i] = 1'b0;
      for (int k = 0; k < int'(N_PORTS); k++) begin
        if (port_hit[k] && port_sig[k] == cmp_sig) hit_vec[i] = 1'b1;
      end
      unique case (state_q[i])
        IDLE: begin
          if (grant[i]) begin
            if (hit_vec[i]) begin
              state_d[i] = RESP;
            end else begin
              state_d[i]    = WAIT;
              wait_sig_d[i] = req_sig_i[i];
            end
          end
        end
        WAIT:    if (hit_vec[i]) state_d[i] = RESP;
        RESP:    if (rsp_ready_i[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
    for (int k = 0; k < int'(N_PORTS); k++) begin
      if (port_wr[k]) begin
        if (cam_present_i[k]) n_hit = n_hit + 1;
        else                  n_miss = n_miss + 1;
      end
    end
    occ_d = OCC_W'(int'(occ_q) + n_miss - n_hit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        state_q[i]    <= IDLE;
        wait_sig_q[i] <= '0;
      end
      occ_q <= '0;
      rr_q  <= '0;
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        state_q[i]    <= state_d[i];
        wait_sig_q[i] <= wait_sig_d[i];
      end
      occ_q <= occ_d;
      rr_q  <= rr_d;
    end
  end

`ifdef FRACTAL_SYNC_SCHED_STATS_EN
  logic [31:0] match_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) match_cnt_q <= '0;
    else         match_cnt_q <= match_cnt_q + 32'(n_hit);
  end
  assign match_cnt_o = match_cnt_q;
`endif

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) rsp_valid_o[i] = (state_q[i] == RESP);
  end

  assign req_ready_o = grant;
  assign cam_sig_o   = port_sig;
  assign cam_write_o = port_wr;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_fractal_sync_mp_cam_sched.sv
`timescale 1ns/1ps
// tb_fractal_sync_mp_cam_sched: directed scenarios on a 1-line instance (checked every cycle against a
// waiter-set model) and a 4-line instance for round-robin, each backed by a small bench CAM.
module tb_fractal_sync_mp_cam_sched;
  localparam int SW = 2;
  localparam int NR = 4;
  localparam int NP = 2;
  localparam int NL_A = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (N_LINES=1) ----------------
  logic [NR-1:0]          a_valid, a_ready, a_rsp_valid, a_rsp_ready;
  logic [NR-1:0][SW-1:0]  a_sig;
  logic [NP-1:0][SW-1:0]  a_cam_sig;
  logic [NP-1:0]          a_cam_wr, a_cam_pres;
  logic [0:0]             a_occ;
  logic [3:0]             a_store;
`ifdef FRACTAL_SYNC_SCHED_STATS_EN
  logic [31:0]            a_match, b_match;
`endif

  fractal_sync_mp_cam_sched #(.SIG_WIDTH(SW), .N_REQ(NR), .N_PORTS(NP), .N_LINES(NL_A)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(a_valid), .req_sig_i(a_sig), .req_ready_o(a_ready),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .cam_sig_o(a_cam_sig), .cam_write_o(a_cam_wr), .cam_present_i(a_cam_pres),
    .occupancy_o(a_occ)
`ifdef FRACTAL_SYNC_SCHED_STATS_EN
    , .match_cnt_o(a_match)
`endif
  );

  always_comb begin
    for (int k = 0; k < NP; k++) a_cam_pres[k] = a_store[a_cam_sig[k]];
  end
  // Bench CAM: a write on a present signature frees it, otherwise stores it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) a_store <= '0;
    else for (int k = 0; k < NP; k++) if (a_cam_wr[k]) a_store[a_cam_sig[k]] <= ~a_store[a_cam_sig[k]];
  end

  // ---------------- instance B (N_LINES=4) ----------------
  logic [NR-1:0]          b_valid, b_ready, b_rsp_valid, b_rsp_ready;
  logic [NR-1:0][SW-1:0]  b_sig;
  logic [NP-1:0][SW-1:0]  b_cam_sig;
  logic [NP-1:0]          b_cam_wr, b_cam_pres;
  logic [2:0]             b_occ;
  logic [3:0]             b_store;

  fractal_sync_mp_cam_sched #(.SIG_WIDTH(SW), .N_REQ(NR), .N_PORTS(NP), .N_LINES(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_valid), .req_sig_i(b_sig), .req_ready_o(b_ready),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .cam_sig_o(b_cam_sig), .cam_write_o(b_cam_wr), .cam_present_i(b_cam_pres),
    .occupancy_o(b_occ)
`ifdef FRACTAL_SYNC_SCHED_STATS_EN
    , .match_cnt_o(b_match)
`endif
  );

  always_comb begin
    for (int k = 0; k < NP; k++) b_cam_pres[k] = b_store[b_cam_sig[k]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_store <= '0;
    else for (int k = 0; k < NP; k++) if (b_cam_wr[k]) b_store[b_cam_sig[k]] <= ~b_store[b_cam_sig[k]];
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of instance A: requester status 0=idle 1=waiting 2=responding; occupancy = #waiters.
  int m_st [NR];
  int m_wsig [NR];
  int m_rr, m_match, m_nmiss, m_free, m_c, m_p, m_nwait;
  bit m_dup;
  int gq[$];
  logic [NR-1:0]          e_ready, e_rsp;
  logic [NP-1:0]          e_wr;
  logic [NP-1:0][SW-1:0]  e_sig;

  function automatic int waiter_of(input int s);
    for (int i = 0; i < NR; i++) if (m_st[i] == 1 && m_wsig[i] == s) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    e_ready = '0; e_rsp = '0; e_wr = '0; e_sig = '0;
    gq.delete();
    m_nwait = 0;
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin m_st[i] = 0; m_wsig[i] = 0; end
      m_rr = 0; m_match = 0;
    end else begin
      for (int i = 0; i < NR; i++) if (m_st[i] == 1) m_nwait++;
      m_free = NL_A - m_nwait;
      m_nmiss = 0;
      for (int j = 0; j < NR; j++) begin
        m_c = (m_rr + j) % NR;
        if (a_valid[m_c] && m_st[m_c] == 0) begin
          m_dup = 0;
          foreach (gq[g]) if (a_sig[gq[g]] == a_sig[m_c]) m_dup = 1;
          m_p = waiter_of(int'(a_sig[m_c]));
          if (!m_dup && gq.size() < NP && (m_p >= 0 || m_nmiss < m_free)) begin
            gq.push_back(m_c);
            if (m_p < 0) m_nmiss++;
          end
        end
      end
      foreach (gq[g]) e_ready[gq[g]] = 1'b1;
      for (int k = 0; k < NP; k++) if (k < gq.size()) begin e_wr[k] = 1'b1; e_sig[k] = a_sig[gq[k]]; end
      for (int i = 0; i < NR; i++) e_rsp[i] = (m_st[i] == 2);
    end
    check("m_ready", 32'(a_ready), 32'(e_ready));
    check("m_cam_wr", 32'(a_cam_wr), 32'(e_wr));
    check("m_cam_sig", 32'(a_cam_sig), 32'(e_sig));
    check("m_rsp_valid", 32'(a_rsp_valid), 32'(e_rsp));
    check("m_occ", 32'(a_occ), 32'(m_nwait));
`ifdef FRACTAL_SYNC_SCHED_STATS_EN
    check("m_match_cnt", a_match, 32'(m_match));
`endif
    if (rst_n) begin
      for (int i = 0; i < NR; i++) if (m_st[i] == 2 && a_rsp_ready[i]) m_st[i] = 0;
      foreach (gq[g]) begin
        m_p = waiter_of(int'(a_sig[gq[g]]));
        if (m_p >= 0) begin m_st[m_p] = 2; m_st[gq[g]] = 2; m_match++; end
        else begin m_st[gq[g]] = 1; m_wsig[gq[g]] = int'(a_sig[gq[g]]); end
      end
      if (gq.size() > 0) m_rr = (gq[gq.size()-1] + 1) % NR;
    end
  end

  // ---------------- driver tasks ----------------
  logic [NR-1:0] gr;

  task automatic step();
    @(negedge clk);
    gr = a_ready;
    @(posedge clk);
    #1;
    a_valid = a_valid & ~gr;
  endtask

  task automatic req(input int i, input int s);
    a_valid[i] = 1'b1;
    a_sig[i]   = s[SW-1:0];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a_valid = '0; a_sig = '0; a_rsp_ready = '1;
    b_valid = '0; b_sig = '0; b_rsp_ready = '1;
    gr = '0;
    a_valid[0] = 1'b1; a_sig[0] = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(a_ready), 0);
    check("rst_occ", 32'(a_occ), 0);
    check("rst_rsp", 32'(a_rsp_valid), 0);
    check("rst_cam_wr", 32'(a_cam_wr), 0);
    check("rst_cam_sig", 32'(a_cam_sig), 0);
    a_valid = '0; a_sig = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin on the 4-line instance
    b_valid = 4'b1111;
    for (int i = 0; i < NR; i++) b_sig[i] = SW'(i);
    #1;
    check("rr_t0_ready", 32'(b_ready), 32'b0011);
    check("rr_t0_sig", 32'(b_cam_sig), 32'h4);
    @(posedge clk); #1;
    b_valid = 4'b1100;
    #1;
    check("rr_t1_ready", 32'(b_ready), 32'b1100);
    check("rr_t1_sig", 32'(b_cam_sig), 32'hE);
    check("rr_t1_occ", 32'(b_occ), 2);
    @(posedge clk); #1;
    b_valid = '0;
    #1;
    check("rr_t2_occ", 32'(b_occ), 4);
    check("rr_t2_ptr", 32'(dut_b.rr_q), 0);
    check("rr_t2_ready", 32'(b_ready), 0);

    // Plain pair
    req(0, 1); #1;
    check("pair_t0_ready", 32'(a_ready), 32'b0001);
    check("pair_t0_wr", 32'(a_cam_wr), 32'b01);
    check("pair_t0_sig", 32'(a_cam_sig[0]), 1);
    step(); #1;
    check("pair_t1_occ", 32'(a_occ), 1);
    step(); step();
    req(2, 1); #1;
    check("pair_t3_ready", 32'(a_ready), 32'b0100);
    check("pair_t3_present", 32'(a_cam_pres[0]), 1);
    step(); #1;
    check("pair_t4_rsp", 32'(a_rsp_valid), 32'b0101);
    check("pair_t4_occ", 32'(a_occ), 0);
`ifdef FRACTAL_SYNC_SCHED_STATS_EN
    check("pair_match", a_match, 1);
`endif
    step(); #1;
    check("pair_t5_rsp", 32'(a_rsp_valid), 0);

    // Same-cycle conflict
    req(0, 1); req(1, 1); #1;
    check("conf_t0_ready", 32'(a_ready), 32'b0001);
    step(); #1;
    check("conf_t1_ready", 32'(a_ready), 32'b0010);
    check("conf_t1_present", 32'(a_cam_pres[0]), 1);
    step(); #1;
    check("conf_t2_rsp", 32'(a_rsp_valid), 32'b0011);
    step();

    // Full stall
    req(0, 1); #1;
    check("stall_t0_ready", 32'(a_ready), 32'b0001);
    step();
    req(1, 0); #1;
    check("stall_t1_ready", 32'(a_ready), 0);
    step(); #1;
    check("stall_t2_blocked", 32'(a_ready), 0);
    req(2, 1); #1;
    check("stall_t2_ready", 32'(a_ready), 32'b0100);
    step(); #1;
    check("stall_t3_rsp", 32'(a_rsp_valid), 32'b0101);
    check("stall_t3_ready", 32'(a_ready), 32'b0010);
    check("stall_t3_sig", 32'(a_cam_sig[0]), 0);
    step(); #1;
    check("stall_t4_occ", 32'(a_occ), 1);
    req(3, 0); #1;
    check("stall_t4_ready", 32'(a_ready), 32'b1000);
    step(); #1;
    check("stall_t5_rsp", 32'(a_rsp_valid), 32'b1010);
    check("stall_t5_occ", 32'(a_occ), 0);
    step();

    // Response backpressure
    req(1, 2); #1;
    check("bp_t0_ready", 32'(a_ready), 32'b0010);
    step();
    a_rsp_ready[0] = 1'b0;
    req(0, 2); #1;
    check("bp_t1_ready", 32'(a_ready), 32'b0001);
    step(); #1;
    check("bp_t2_rsp", 32'(a_rsp_valid), 32'b0011);
    req(0, 3);
    for (int n = 0; n < 5; n++) begin
      #1;
      check("bp_hold_rsp", 32'(a_rsp_valid[0]), 1);
      check("bp_hold_ready", 32'(a_ready[0]), 0);
      step();
    end
    a_rsp_ready[0] = 1'b1; #1;
    check("bp_accept_rsp", 32'(a_rsp_valid[0]), 1);
    step(); #1;
    check("bp_idle_rsp", 32'(a_rsp_valid[0]), 0);
    check("bp_regrant", 32'(a_ready), 32'b0001);
    step(); #1;
    check("bp_occ", 32'(a_occ), 1);
    req(3, 3); #1;
    check("bp_partner_ready", 32'(a_ready), 32'b1000);
    step(); #1;
    check("bp_partner_rsp", 32'(a_rsp_valid), 32'b1001);
    step();

    // Reset mid-wait
    req(1, 1); #1;
    check("rw_t0_ready", 32'(a_ready), 32'b0010);
    step();
    a_rsp_ready = 4'b1001;
    req(2, 1); #1;
    check("rw_t1_ready", 32'(a_ready), 32'b0100);
    step(); #1;
    check("rw_t2_rsp", 32'(a_rsp_valid), 32'b0110);
    req(0, 3); #1;
    check("rw_t2_ready", 32'(a_ready), 32'b0001);
    step(); #1;
    check("rw_t3_occ", 32'(a_occ), 1);
    check("rw_t3_rsp", 32'(a_rsp_valid), 32'b0110);
    #1 rst_n = 1'b0;
    #1;
    check("rw_rst_rsp", 32'(a_rsp_valid), 0);
    check("rw_rst_occ", 32'(a_occ), 0);
`ifdef FRACTAL_SYNC_SCHED_STATS_EN
    check("rw_rst_match", a_match, 0);
`endif
    a_valid = '0; a_rsp_ready = '1;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rw_post_rsp", 32'(a_rsp_valid), 0);
    check("rw_post_occ", 32'(a_occ), 0);
    req(3, 3); #1;
    check("rw_post_ready", 32'(a_ready), 32'b1000);
    check("rw_post_present", 32'(a_cam_pres[0]), 0);
    step(); #1;
    check("rw_post_occ1", 32'(a_occ), 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
